tracker_query_scheduler: RTL and testbench

TRACKER_QUERY_SCHEDULER -- requirements
Module: tracker_query_scheduler

---
 rtl/tracker_query_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_tracker_query_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tracker_query_scheduler.sv
// Purpose: round-robin arbiter that serialises lookback queries from NUM_REQ requesters onto one signal tracker.
// Latency: response valid 2+SETTLE_CYCLES cycles after acceptance; range-check rejects respond in the next cycle.
// Backpressure: one query in flight; req_ready stays low until the response handshake completes.
module tracker_query_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int BUFFER_WIDTH  = 8,
    parameter int SETTLE_CYCLES = 1,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     counter,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][31:0]        req_lookback,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [ID_W-1:0]                 resp_id,
    output logic signed [31:0]              resp_start,
    output logic signed [31:0]              resp_end,
    output logic                            resp_err,
    output logic [31:0]                     trk_value,
    output logic                            trk_recalc,
    input  logic signed [1:0][31:0]         trk_time,
    output logic [31:0]                     trk_prev_end,
    output logic                            trk_update_end
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        SETTLE,
        RESPOND
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant_q;
    logic [31:0]       lookback_q;
    logic [3:0]        settle_cnt_q;
    logic [31:0]       shadow_q [NUM_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic [31:0]       lb_sel;
    logic [32:0]       counter_p1;
    logic              range_bad;
    logic              settle_done;
    logic [31:0]       end_sample;

    // Round-robin search starting at the pointer; only offered while idle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (state_q == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Range check on the lookback being accepted; counter+1 is widened so it cannot wrap.
    always_comb begin
        lb_sel      = req_lookback[grant_idx];
        counter_p1  = {1'b0, counter} + 33'd1;
        range_bad   = (lb_sel == 32'd0) ||
                      (lb_sel > 32'(BUFFER_WIDTH)) ||
                      ({1'b0, lb_sel} > counter_p1);
        settle_done = (settle_cnt_q == 4'(SETTLE_CYCLES - 1));
        end_sample  = trk_time[1];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and tracker-facing outputs, decoded from the current state.
    always_comb begin
        state_d        = state_q;
        resp_valid     = 1'b0;
        trk_update_end = 1'b0;
        trk_prev_end   = '0;
        trk_recalc     = 1'b0;
        trk_value      = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = range_bad ? RESPOND : LOAD;
                end
            end
            LOAD: begin
                trk_update_end = 1'b1;
                trk_prev_end   = shadow_q[grant_q];
                trk_value      = lookback_q;
                state_d        = ISSUE;
            end
            ISSUE: begin
                trk_recalc = 1'b1;
                trk_value  = lookback_q;
                state_d    = SETTLE;
            end
            SETTLE: begin
                trk_value = lookback_q;
                if (settle_done) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, settle timing, response capture and per-requester previous-end shadows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            grant_q      <= '0;
            lookback_q   <= '0;
            settle_cnt_q <= '0;
            resp_id      <= '0;
            resp_start   <= '0;
            resp_end     <= '0;
            resp_err     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        grant_q    <= grant_idx;
                        resp_id    <= grant_idx;
                        lookback_q <= lb_sel;
                        ptr_q      <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                        if (range_bad) begin
                            resp_start <= -32'sd1;
                            resp_end   <= -32'sd1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    settle_cnt_q <= '0;
                end
                SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                    if (settle_done) begin
                        resp_start <= trk_time[0];
                        resp_end   <= trk_time[1];
                        resp_err   <= 1'b0;
                        // A not-found result leaves the requester's previous end untouched.
                        if (end_sample != 32'hFFFF_FFFF) begin
                            shadow_q[grant_q] <= end_sample;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_query_scheduler.sv
module tb_tracker_query_scheduler;

    localparam int NUM_REQ = 2;
    localparam int BW      = 8;
    localparam int SC      = 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [31:0]                counter;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0][31:0]   req_lookback;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [0:0]                 resp_id;
    logic signed [31:0]         resp_start;
    logic signed [31:0]         resp_end;
    logic                       resp_err;
    logic [31:0]                trk_value;
    logic                       trk_recalc;
    logic signed [1:0][31:0]    trk_time;
    logic [31:0]                trk_prev_end;
    logic                       trk_update_end;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] st;
        logic [31:0] en;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_shadow [NUM_REQ];
    int          ptr;

    tracker_query_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .BUFFER_WIDTH (BW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .counter       (counter),
        .req_valid     (req_valid),
        .req_lookback  (req_lookback),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_start    (resp_start),
        .resp_end      (resp_end),
        .resp_err      (resp_err),
        .trk_value     (trk_value),
        .trk_recalc    (trk_recalc),
        .trk_time      (trk_time),
        .trk_prev_end  (trk_prev_end),
        .trk_update_end(trk_update_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_start"}, resp_start, 32'd0);
        chk({tag, "_resp_end"}, resp_end, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_trk_recalc"}, 32'(trk_recalc), 32'd0);
        chk({tag, "_trk_update_end"}, 32'(trk_update_end), 32'd0);
        chk({tag, "_trk_value"}, trk_value, 32'd0);
        chk({tag, "_trk_prev_end"}, trk_prev_end, 32'd0);
    endtask

    // One complete query: request under `mask`, tracker answers {ts,te},
    // consumer holds resp_ready low for `hold` cycles before the handshake.
    task automatic do_txn(input logic [1:0] mask, input logic [31:0] lb, input logic [31:0] cnt,
                          input logic [31:0] ts, input logic [31:0] te, input int hold);
        int   g;
        int   idx;
        int   edges;
        int   recalc_n;
        int   upd_n;
        logic exp_bad;
        exp_t e;
        exp_t got;

        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (g < 0 && mask[idx[0]]) g = idx;
        end
        exp_bad = (lb == 32'd0) || (lb > 32'(BW)) || ({1'b0, lb} > ({1'b0, cnt} + 33'd1));
        e.id  = g;
        e.err = exp_bad;
        e.st  = exp_bad ? 32'hFFFF_FFFF : ts;
        e.en  = exp_bad ? 32'hFFFF_FFFF : te;
        sb.push_back(e);

        @(negedge clk);
        req_valid       = mask;
        req_lookback[0] = lb;
        req_lookback[1] = lb;
        counter         = cnt;
        trk_time[0]     = ts;
        trk_time[1]     = te;
        resp_ready      = 1'b0;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << g));

        @(posedge clk);
        ptr      = (g + 1) % NUM_REQ;
        edges    = 0;
        recalc_n = 0;
        upd_n    = 0;
        @(negedge clk);
        while (!resp_valid && edges < 20) begin
            if (trk_update_end) begin
                upd_n++;
                chk("prev_end", trk_prev_end, model_shadow[g]);
                chk("value_load", trk_value, lb);
            end
            if (trk_recalc) begin
                recalc_n++;
                chk("value_issue", trk_value, lb);
            end
            @(negedge clk);
            edges++;
        end
        // Edges after the accepting edge before resp_valid is seen.
        chk("latency", 32'(edges), exp_bad ? 32'd0 : 32'(2 + SC));
        chk("recalc_pulses", 32'(recalc_n), exp_bad ? 32'd0 : 32'd1);
        chk("update_end_cycles", 32'(upd_n), exp_bad ? 32'd0 : 32'd1);

        got = sb.pop_front();
        req_valid = 2'b11;
        for (int h = 0; h <= hold; h++) begin
            #1;
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_id", 32'(resp_id), 32'(got.id));
            chk("resp_start", resp_start, got.st);
            chk("resp_end", resp_end, got.en);
            chk("resp_err", 32'(resp_err), 32'(got.err));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (h == hold) resp_ready = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
        if (!exp_bad && te != 32'hFFFF_FFFF) model_shadow[g] = te;
    endtask

    initial begin
        rst             = 1'b0;
        counter         = '0;
        req_valid       = '0;
        req_lookback[0] = '0;
        req_lookback[1] = '0;
        resp_ready      = 1'b0;
        trk_time[0]     = '0;
        trk_time[1]     = '0;
        ptr             = 0;
        model_shadow[0] = '0;
        model_shadow[1] = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        // Basic query, then alternating grants with both requesters valid.
        do_txn(2'b01, 32'd3, 32'd12, 32'd10, 32'd11, 0);
        do_txn(2'b11, 32'd2, 32'd12, 32'd5, 32'd7, 0);
        do_txn(2'b11, 32'd4, 32'd12, 32'd1, 32'd4, 0);
        do_txn(2'b11, 32'd1, 32'd12, 32'd20, 32'd21, 0);

        // Range-check rejects: too long, beyond counter+1, zero.
        do_txn(2'b01, 32'd9, 32'd100, 32'd3, 32'd3, 0);
        do_txn(2'b10, 32'd5, 32'd2, 32'd3, 32'd3, 0);
        do_txn(2'b01, 32'd0, 32'd50, 32'd3, 32'd3, 0);

        // Not-found result leaves shadow alone; next query on the same requester shows it.
        do_txn(2'b10, 32'd2, 32'd50, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_txn(2'b10, 32'd8, 32'd50, 32'd30, 32'd37, 4);

        // Boundaries: lookback exactly counter+1, and counter=0 with lookback 1.
        do_txn(2'b01, 32'd3, 32'd2, 32'd0, 32'd2, 0);
        do_txn(2'b10, 32'd1, 32'd0, 32'd0, 32'd0, 0);

        // Reset while the query is settling.
        @(negedge clk);
        req_valid       = 2'b01;
        req_lookback[0] = 32'd2;
        counter         = 32'd5;
        trk_time[0]     = 32'd4;
        trk_time[1]     = 32'd5;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        #1;
        chk_reset_outputs("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resp_in_reset", 32'(resp_valid), 32'd0);
        end
        rst             = 1'b1;
        ptr             = 0;
        model_shadow[0] = '0;
        model_shadow[1] = '0;
        do_txn(2'b11, 32'd2, 32'd9, 32'd3, 32'd4, 0);
        do_txn(2'b11, 32'd2, 32'd9, 32'd6, 32'd8, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
